fir_tap_vin_buffer_ctrl: RTL and testbench

FIR_TAP_VIN_BUFFER_CTRL -- requirements
Module: fir_tap_vin_buffer_ctrl

---
 rtl/fir_tap_vin_buffer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fir_tap_vin_buffer_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_vin_buffer_ctrl.sv
// Packs 32-bit FIR tap words into 256-bit DDR beats, buffers one line of beats,
// then issues a single DDR write burst for that line and pulses done when it is committed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for wr_start_i; line index captured on start
// S_COLLECT | accepting tap words, packing beats into the FIFO
// S_REQ     | full line buffered, burst request raised to the DDR side
// S_BURSTING| DDR controller draining beats, waiting for burst finish
// S_DONE    | one-cycle done pulse, leftover beats flushed
module fir_tap_vin_buffer_ctrl #(
  parameter real TCQ           = 0.1,
  parameter int  ADDR_WIDTH    = 30,
  parameter int  DATA_WIDTH    = 32,
  parameter int  MEM_DATA_BITS = 256,
  parameter int  BURST_LEN     = 128
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     wr_start_i,
  input  logic [15:0]              wr_line_i,
  input  logic                     tap_data_vld_i,
  input  logic [DATA_WIDTH-1:0]    tap_data_i,
  output logic                     tap_data_rdy_o,
  output logic                     wr_line_done_o,
  output logic                     wr_ddr_req_o,
  output logic [7:0]               wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
  input  logic                     wr_ddr_data_req_i,
  output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
  input  logic                     wr_ddr_finish_i,
  output logic                     underflow_err_o
);

  localparam int LANES  = MEM_DATA_BITS / DATA_WIDTH;
  localparam int LANE_W = $clog2(LANES);
  localparam int WORDS  = BURST_LEN * LANES;
  localparam int WCNT_W = $clog2(WORDS);
  localparam int PTR_W  = $clog2(BURST_LEN);
  localparam int CNT_W  = $clog2(BURST_LEN + 1);

  // TCQ only shapes clock-to-Q in behavioural models; nothing to build for it here.
  if (TCQ < 0.0) begin : g_tcq_negative
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_REQ,
    S_BURSTING,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [LANE_W-1:0]        lane_cnt;
  logic [WCNT_W-1:0]        word_cnt;
  logic                     words_full;
  logic [MEM_DATA_BITS-1:0] beat_q;
  logic                     beat_pend;

  logic [MEM_DATA_BITS-1:0] fifo_mem [BURST_LEN];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         fifo_cnt;

  logic fifo_empty;
  logic fifo_wr;
  logic fifo_pop;
  logic fifo_flush;
  logic tap_acc;
  logic start_acc;
  logic req_nxt;

  assign fifo_empty     = (fifo_cnt == '0);
  assign fifo_wr        = beat_pend;
  assign fifo_pop       = wr_ddr_data_req_i && !fifo_empty &&
                          ((state == S_REQ) || (state == S_BURSTING));
  assign fifo_flush     = (state == S_DONE);
  assign start_acc      = (state == S_IDLE) && wr_start_i;
  assign tap_data_rdy_o = (state == S_COLLECT) && !words_full;
  assign tap_acc        = tap_data_vld_i && tap_data_rdy_o;
  assign wr_line_done_o = (state == S_DONE);
  assign wr_ddr_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wr_start_i) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (fifo_wr && (fifo_cnt == CNT_W'(BURST_LEN - 1))) state_nxt = S_REQ;
      end
      S_REQ: begin
        // A finish without any beats still closes the line rather than stalling.
        if (wr_ddr_finish_i)        state_nxt = S_DONE;
        else if (wr_ddr_data_req_i) state_nxt = S_BURSTING;
        else                        req_nxt   = 1'b1;
      end
      S_BURSTING: begin
        if (wr_ddr_finish_i) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ddr_clk_i) begin
    if (!ddr_rst_n_i) begin
      state           <= S_IDLE;
      lane_cnt        <= '0;
      word_cnt        <= '0;
      words_full      <= 1'b0;
      beat_q          <= '0;
      beat_pend       <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      wr_ddr_req_o    <= 1'b0;
      wr_ddr_len_o    <= '0;
      wr_ddr_addr_o   <= '0;
      underflow_err_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ddr_req_o <= req_nxt;
      beat_pend    <= 1'b0;

      if (start_acc) begin
        lane_cnt      <= '0;
        word_cnt      <= '0;
        words_full    <= 1'b0;
        wr_ddr_addr_o <= ADDR_WIDTH'({2'd0, 2'd1, 3'd0, wr_line_i, 7'd0});
      end else if (tap_acc) begin
        beat_q[int'(lane_cnt) * DATA_WIDTH +: DATA_WIDTH] <= tap_data_i;
        lane_cnt  <= lane_cnt + 1'b1;
        beat_pend <= (lane_cnt == LANE_W'(LANES - 1));
        // Counter parks on the last word; the full flag closes the ready window.
        if (word_cnt == WCNT_W'(WORDS - 1)) words_full <= 1'b1;
        else                                word_cnt   <= word_cnt + 1'b1;
      end

      if ((state == S_COLLECT) && (state_nxt == S_REQ)) wr_ddr_len_o <= 8'(BURST_LEN);

      if (wr_ddr_data_req_i && fifo_empty) underflow_err_o <= 1'b1;

      if (fifo_flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
        if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
      end
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge ddr_clk_i) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= beat_q;
  end

endmodule

// File: tb/tb_fir_tap_vin_buffer_ctrl.sv
// Directed-plus-random bench: tap words are tracked in a queue, beats are
// rebuilt from it by plain lane packing, addresses from the line-address formula.
module tb_fir_tap_vin_buffer_ctrl;

  logic         ddr_clk_i;
  logic         ddr_rst_n_i;
  logic         wr_start_i;
  logic [15:0]  wr_line_i;
  logic         tap_data_vld_i;
  logic [31:0]  tap_data_i;
  logic         tap_data_rdy_o;
  logic         wr_line_done_o;
  logic         wr_ddr_req_o;
  logic [7:0]   wr_ddr_len_o;
  logic [29:0]  wr_ddr_addr_o;
  logic         wr_ddr_data_req_i;
  logic [255:0] wr_ddr_data_o;
  logic         wr_ddr_finish_i;
  logic         underflow_err_o;

  fir_tap_vin_buffer_ctrl dut (
    .ddr_clk_i         (ddr_clk_i),
    .ddr_rst_n_i       (ddr_rst_n_i),
    .wr_start_i        (wr_start_i),
    .wr_line_i         (wr_line_i),
    .tap_data_vld_i    (tap_data_vld_i),
    .tap_data_i        (tap_data_i),
    .tap_data_rdy_o    (tap_data_rdy_o),
    .wr_line_done_o    (wr_line_done_o),
    .wr_ddr_req_o      (wr_ddr_req_o),
    .wr_ddr_len_o      (wr_ddr_len_o),
    .wr_ddr_addr_o     (wr_ddr_addr_o),
    .wr_ddr_data_req_i (wr_ddr_data_req_i),
    .wr_ddr_data_o     (wr_ddr_data_o),
    .wr_ddr_finish_i   (wr_ddr_finish_i),
    .underflow_err_o   (underflow_err_o)
  );

  initial ddr_clk_i = 1'b0;
  always #5 ddr_clk_i = ~ddr_clk_i;

  int           n_cmp = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  int           exp_done = 0;
  logic [15:0]  cur_line;
  logic [31:0]  words[$];

  always @(negedge ddr_clk_i) if (wr_line_done_o === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] exp_addr(input logic [15:0] line);
    logic [31:0] a;
    a = (32'd1 << 26) | (32'(line) << 7);
    return a[29:0];
  endfunction

  function automatic logic [255:0] exp_beat(input int i);
    logic [255:0] b;
    b = '0;
    for (int j = 0; j < 8; j++) b[j*32 +: 32] = words[i*8 + j];
    return b;
  endfunction

  function automatic logic [255:0] ramp_beat0();
    logic [255:0] b;
    for (int j = 0; j < 8; j++) b[j*32 +: 32] = 32'(j);
    return b;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},   tap_data_rdy_o,  '0);
    chk({tag, "_done"},  wr_line_done_o,  '0);
    chk({tag, "_req"},   wr_ddr_req_o,    '0);
    chk({tag, "_len"},   wr_ddr_len_o,    '0);
    chk({tag, "_addr"},  wr_ddr_addr_o,   '0);
    chk({tag, "_data"},  wr_ddr_data_o,   '0);
    chk({tag, "_uflow"}, underflow_err_o, '0);
  endtask

  task automatic start_line(input logic [15:0] line);
    wr_start_i = 1'b1;
    wr_line_i  = line;
    @(negedge ddr_clk_i);
    wr_start_i = 1'b0;
    wr_line_i  = 16'($urandom);
    cur_line   = line;
    chk("addr_latch", wr_ddr_addr_o, exp_addr(line));
  endtask

  task automatic feed(input int target, input int gap_pct, input bit seq);
    int cyc;
    int rdy_low;
    cyc = 0;
    rdy_low = 0;
    words.delete();
    while (words.size() < target && cyc < 8000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        tap_data_vld_i = 1'b0;
      end else begin
        tap_data_vld_i = 1'b1;
        tap_data_i     = seq ? 32'(words.size()) : $urandom;
      end
      if (tap_data_vld_i && tap_data_rdy_o) words.push_back(tap_data_i);
      else if (tap_data_vld_i) rdy_low++;
      @(negedge ddr_clk_i);
      cyc++;
    end
    tap_data_vld_i = 1'b0;
    chk("feed_count", 256'(words.size()), 256'(target));
    chk("feed_rdy_low", 256'(rdy_low), '0);
  endtask

  task automatic extra_words(input int n);
    for (int k = 0; k < n; k++) begin
      tap_data_vld_i = 1'b1;
      tap_data_i     = $urandom;
      chk("rdy_after_full", tap_data_rdy_o, '0);
      @(negedge ddr_clk_i);
    end
    tap_data_vld_i = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (wr_ddr_req_o !== 1'b1 && n < 16) begin
      @(negedge ddr_clk_i);
      n++;
    end
    chk("req_rise", wr_ddr_req_o, 256'd1);
    chk("len", wr_ddr_len_o, 256'd128);
    chk("addr_hold", wr_ddr_addr_o, exp_addr(cur_line));
  endtask

  task automatic burst(input int n_pops, input bit fin_last, input int start_at);
    logic [255:0] e;
    for (int i = 0; i < n_pops; i++) begin
      e = (i < words.size() / 8) ? exp_beat(i) : '0;
      chk("beat", wr_ddr_data_o, e);
      if (i == 128) chk("uflow_before", underflow_err_o, '0);
      wr_ddr_data_req_i = 1'b1;
      wr_ddr_finish_i   = fin_last && (i == n_pops - 1);
      wr_start_i        = (i == start_at);
      wr_line_i         = 16'hAAAA;
      @(negedge ddr_clk_i);
      wr_start_i = 1'b0;
      if (i == 0) chk("req_clear", wr_ddr_req_o, '0);
    end
    wr_ddr_data_req_i = 1'b0;
    if (n_pops > 128) chk("uflow_set", underflow_err_o, 256'd1);
    if (!fin_last) begin
      chk("empty_before_fin", wr_ddr_data_o, '0);
      wr_ddr_finish_i = 1'b1;
      @(negedge ddr_clk_i);
    end
    wr_ddr_finish_i = 1'b0;
    chk("done_pulse", wr_line_done_o, 256'd1);
    chk("empty_in_done", wr_ddr_data_o, '0);
    chk("req_in_done", wr_ddr_req_o, '0);
    @(negedge ddr_clk_i);
    chk("done_single", wr_line_done_o, '0);
    chk("addr_after", wr_ddr_addr_o, exp_addr(cur_line));
    exp_done++;
  endtask

  initial begin
    int hi_cnt;
    ddr_rst_n_i       = 1'b0;
    wr_start_i        = 1'b0;
    wr_line_i         = '0;
    tap_data_vld_i    = 1'b0;
    tap_data_i        = '0;
    wr_ddr_data_req_i = 1'b0;
    wr_ddr_finish_i   = 1'b0;
    cur_line          = '0;
    repeat (3) @(negedge ddr_clk_i);
    chk_all_zero("reset");
    ddr_rst_n_i = 1'b1;
    @(negedge ddr_clk_i);

    // Line 0x0005, ramp data, no gaps
    start_line(16'h0005);
    feed(1024, 0, 1'b1);
    wait_req();
    chk("beat0_ramp", wr_ddr_data_o, ramp_beat0());
    burst(128, 1'b0, -1);
    chk("done_cnt_1", 256'(done_cnt), 256'(exp_done));

    // Line 0xFFFF, same ramp with ~50% valid gaps; finish lands with the last pop
    start_line(16'hFFFF);
    feed(1024, 50, 1'b1);
    wait_req();
    chk("beat0_ramp_gaps", wr_ddr_data_o, ramp_beat0());
    burst(128, 1'b1, -1);
    chk("done_cnt_2", 256'(done_cnt), 256'(exp_done));

    // Random words, overflow words, start during burst, one pop too many
    start_line(16'h3C5A);
    feed(1024, 20, 1'b0);
    extra_words(5);
    wait_req();
    burst(129, 1'b0, 10);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (wr_ddr_req_o === 1'b1 || tap_data_rdy_o === 1'b1) hi_cnt++;
      @(negedge ddr_clk_i);
    end
    chk("no_second_line", 256'(hi_cnt), '0);
    chk("uflow_sticky", underflow_err_o, 256'd1);
    chk("done_cnt_3", 256'(done_cnt), 256'(exp_done));

    // Reset in the middle of a line
    start_line(16'h1234);
    feed(600, 0, 1'b0);
    ddr_rst_n_i    = 1'b0;
    tap_data_vld_i = 1'b1;
    @(negedge ddr_clk_i);
    chk_all_zero("mid_reset");
    ddr_rst_n_i    = 1'b1;
    tap_data_vld_i = 1'b0;
    repeat (5) @(negedge ddr_clk_i);
    chk("no_done_after_reset", 256'(done_cnt), 256'(exp_done));
    chk("idle_after_reset", tap_data_rdy_o, '0);

    start_line(16'h0002);
    feed(1024, 0, 1'b0);
    wait_req();
    burst(128, 1'b1, -1);
    chk("uflow_clear_after", underflow_err_o, '0);
    repeat (2) @(negedge ddr_clk_i);
    chk("done_cnt_final", 256'(done_cnt), 256'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
